// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg: shared types and constants for the AES-128 round sequencer.
// Optional build macro AES_SCHED_TIMEOUT_EN adds the ERR state to the state enum.
package aes_sched_pkg;

    localparam int AES128_ROUNDS = 10;
    localparam int RK_IDX_W      = 4;

    typedef logic [127:0] block_t;

`ifdef AES_SCHED_TIMEOUT_EN
    typedef enum logic [2:0] {
        IDLE,
        KEY,
        GO,
        WAIT,
        OUT,
        ERR
    } sched_state_e;
`else
    typedef enum logic [2:0] {
        IDLE,
        KEY,
        GO,
        WAIT,
        OUT
    } sched_state_e;
`endif

endpackage

// File: rtl/aes_sched_wdog.sv
// aes_sched_wdog: loadable down-counter that flags expiry when it reaches zero.
// Used by aes_round_sched only when AES_SCHED_TIMEOUT_EN is defined.
module aes_sched_wdog
    import aes_sched_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] cnt_q;

    // Load takes priority; otherwise count down and saturate at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/aes_round_sched.sv
// aes_round_sched: sequences one round_tf instance through a full AES-128
// encryption (initial AddRoundKey, nine full rounds, final round from the
// ShiftRows tap), fetching round keys 0..10 over a request/valid handshake.
// Build macro AES_SCHED_TIMEOUT_EN: watchdog on rtf_done_i with sticky ERR state.
module aes_round_sched
    import aes_sched_pkg::*;
#(
    parameter int NUM_ROUNDS     = AES128_ROUNDS,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [127:0]        pt_i,
    output logic                ready_o,
    output logic                rk_req_o,
    output logic [RK_IDX_W-1:0] rk_idx_o,
    input  logic                rk_valid_i,
    input  logic [127:0]        rk_i,
    output logic                rtf_start_o,
    output logic [127:0]        rtf_b_o,
    input  logic [127:0]        rtf_sr_i,
    input  logic [127:0]        rtf_mc_i,
    input  logic                rtf_done_i,
    output logic [127:0]        ct_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                err_o
);

    localparam logic [RK_IDX_W-1:0] LAST_RND = RK_IDX_W'(NUM_ROUNDS);

    sched_state_e        state_q;
    sched_state_e        state_d;
    logic [RK_IDX_W-1:0] ctr_q;
    block_t              blk_q;
    logic                last_rnd;

    assign last_rnd = (ctr_q == LAST_RND);

`ifdef AES_SCHED_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic wdog_expired;

    // Armed in GO so that expiry lands exactly TIMEOUT_CYCLES cycles into WAIT.
    aes_sched_wdog #(
        .WIDTH (WDOG_W)
    ) u_wdog (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == GO),
        .load_val_i (WDOG_W'(TIMEOUT_CYCLES - 1)),
        .dec_i      (state_q == WAIT),
        .expired_o  (wdog_expired)
    );
`else
    // The watchdog limit has no effect when the timeout is compiled out.
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Block state and round counter: load plaintext, fold in keys, take round results.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q <= '0;
            blk_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        blk_q <= pt_i;
                        ctr_q <= '0;
                    end
                end
                KEY: begin
                    if (rk_valid_i) begin
                        blk_q <= blk_q ^ rk_i;
                        if (!last_rnd) begin
                            ctr_q <= ctr_q + RK_IDX_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (rtf_done_i) begin
                        blk_q <= last_rnd ? rtf_sr_i : rtf_mc_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic; done is only looked at in WAIT, never in GO.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = KEY;
                end
            end
            KEY: begin
                if (rk_valid_i) begin
                    state_d = last_rnd ? OUT : GO;
                end
            end
            GO: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (rtf_done_i) begin
                    state_d = KEY;
                end
`ifdef AES_SCHED_TIMEOUT_EN
                else if (wdog_expired) begin
                    state_d = ERR;
                end
`endif
            end
            OUT: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
`ifdef AES_SCHED_TIMEOUT_EN
            ERR: begin
                state_d = ERR;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state; ciphertext is exposed only while valid.
    always_comb begin
        ready_o     = (state_q == IDLE);
        rk_req_o    = (state_q == KEY);
        rtf_start_o = (state_q == GO);
        valid_o     = (state_q == OUT);
`ifdef AES_SCHED_TIMEOUT_EN
        err_o       = (state_q == ERR);
`else
        err_o       = 1'b0;
`endif
        rk_idx_o    = ctr_q;
        rtf_b_o     = blk_q;
        ct_o        = valid_o ? blk_q : '0;
    end

endmodule

// File: tb/tb_aes_round_sched.sv
// tb_aes_round_sched: randomized self-checking bench for aes_round_sched.
// Provides a behavioural round_tf (EN_MC=1) with configurable latency, a key
// store with configurable response delay, and an AES-128 reference model.
// Build macro AES_SCHED_TIMEOUT_EN additionally exercises the watchdog.
module tb_aes_round_sched;
    import aes_sched_pkg::*;

    localparam int     NUM_ROUNDS     = 10;
    localparam int     TIMEOUT_CYCLES = 64;
    localparam block_t FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam block_t FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam block_t FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [127:0] pt_i;
    logic         ready_o;
    logic         rk_req_o;
    logic [3:0]   rk_idx_o;
    logic         rk_valid_i;
    logic [127:0] rk_i;
    logic         rtf_start_o;
    logic [127:0] rtf_b_o;
    logic [127:0] rtf_sr_i;
    logic [127:0] rtf_mc_i;
    logic         rtf_done_i;
    logic [127:0] ct_o;
    logic         valid_o;
    logic         ready_i;
    logic         err_o;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     acc_cyc = 0;
    int     key_delay = 0;
    int     rtf_lat = 2;
    bit     rtf_stall = 1'b0;
    logic [7:0] sbox_tab [256];
    block_t rk_table [11];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    aes_round_sched #(
        .NUM_ROUNDS     (NUM_ROUNDS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .pt_i        (pt_i),
        .ready_o     (ready_o),
        .rk_req_o    (rk_req_o),
        .rk_idx_o    (rk_idx_o),
        .rk_valid_i  (rk_valid_i),
        .rk_i        (rk_i),
        .rtf_start_o (rtf_start_o),
        .rtf_b_o     (rtf_b_o),
        .rtf_sr_i    (rtf_sr_i),
        .rtf_mc_i    (rtf_mc_i),
        .rtf_done_i  (rtf_done_i),
        .ct_o        (ct_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .err_o       (err_o)
    );

    // ---------------- AES arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic buildSbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // SubBytes followed by ShiftRows; byte index is row + 4*column, MSB first.
    function automatic block_t subShift(input block_t s);
        block_t o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (r + 4 * c) -: 8] = sbox_tab[s[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8]];
        return o;
    endfunction

    function automatic block_t mixCols(input block_t s);
        block_t o = '0;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127 - 32 * c -: 32];
            o[127 - 32 * c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                                     a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                                     a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                                     gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
        end
        return o;
    endfunction

    task automatic expandKey(input block_t key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
                    ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_table[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic block_t aesRef(input block_t pt);
        block_t s = pt ^ rk_table[0];
        for (int r = 1; r <= NUM_ROUNDS; r++) begin
            s = subShift(s);
            if (r != NUM_ROUNDS) s = mixCols(s);
            s = s ^ rk_table[r];
        end
        return s;
    endfunction

    function automatic block_t randBlock();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- behavioural round_tf: done rtf_lat cycles after start ----------------
    logic   rtf_busy;
    int     rtf_rem;
    block_t rtf_sr_q;
    block_t rtf_mc_q;

    always @(posedge clk) begin
        if (rst) begin
            rtf_busy <= 1'b0;
            rtf_rem  <= 0;
        end else if (rtf_start_o) begin
            rtf_busy <= 1'b1;
            rtf_rem  <= rtf_lat - 1;
            rtf_sr_q <= subShift(rtf_b_o);
            rtf_mc_q <= mixCols(subShift(rtf_b_o));
        end else if (rtf_busy && rtf_rem > 0) begin
            rtf_rem <= rtf_rem - 1;
        end
    end

    assign rtf_done_i = rtf_busy && (rtf_rem == 0) && !rtf_stall;
    assign rtf_sr_i   = rtf_sr_q;
    assign rtf_mc_i   = rtf_mc_q;

    // ---------------- key store: answers after key_delay wait cycles ----------------
    int kwait;

    always @(posedge clk) begin
        if (rst || !rk_req_o || rk_valid_i) kwait <= 0;
        else kwait <= kwait + 1;
    end

    assign rk_valid_i = rk_req_o && (kwait >= key_delay);
    assign rk_i       = (rk_idx_o <= 4'd10) ? rk_table[rk_idx_o] : '0;

    // ---------------- checking ----------------
    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Key request monitor: indices arrive in order 0..10 and stay put while waiting.
    int         exp_idx = 0;
    bit         req_waiting = 1'b0;
    logic [3:0] held_idx = 4'd0;

    always @(negedge clk) begin
        if (rst) begin
            req_waiting <= 1'b0;
            exp_idx     <= 0;
        end else begin
            if (ready_o && start_i) exp_idx <= 0;
            if (req_waiting) begin
                checkOutput("rk_req_hold", 128'(rk_req_o), 128'd1);
                checkOutput("rk_idx_hold", 128'(rk_idx_o), 128'(held_idx));
            end
            if (rk_req_o && rk_valid_i) begin
                checkOutput("rk_idx_seq", 128'(rk_idx_o), 128'(exp_idx));
                exp_idx     <= exp_idx + 1;
                req_waiting <= 1'b0;
            end else if (rk_req_o) begin
                req_waiting <= 1'b1;
                held_idx    <= rk_idx_o;
            end else begin
                req_waiting <= 1'b0;
            end
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"},  128'(ready_o), 128'd1);
        checkOutput({tag, "_rkreq"},  128'(rk_req_o), 128'd0);
        checkOutput({tag, "_rkidx"},  128'(rk_idx_o), 128'd0);
        checkOutput({tag, "_start"},  128'(rtf_start_o), 128'd0);
        checkOutput({tag, "_valid"},  128'(valid_o), 128'd0);
        checkOutput({tag, "_err"},    128'(err_o), 128'd0);
        checkOutput({tag, "_ct"},     ct_o, 128'd0);
        checkOutput({tag, "_rtfb"},   rtf_b_o, 128'd0);
    endtask

    // Called at a negedge while idle: start for one cycle, accept edge ends this cycle.
    task automatic applyStimulus(input block_t pt);
        checkOutput("ready_before_start", 128'(ready_o), 128'd1);
        pt_i    = pt;
        start_i = 1'b1;
        acc_cyc = cyc;
        @(negedge clk);
        start_i = 1'b0;
        pt_i    = randBlock();
        checkOutput("ready_after_accept", 128'(ready_o), 128'd0);
    endtask

    task automatic waitForValid(output int lat);
        lat = -1;
        for (int i = 0; i < 3000 && lat < 0; i++) begin
            if (valid_o) lat = cyc - acc_cyc;
            else @(negedge clk);
        end
        if (lat < 0) checkOutput("valid_timeout", 128'd0, 128'd1);
    endtask

    task automatic checkBlock(input string tag, input block_t exp_ct, input int lat, input int d, input int l);
        checkOutput({tag, "_ct"}, ct_o, exp_ct);
        checkOutput({tag, "_lat"}, 128'(lat), 128'(12 + 10 * (1 + l) + 11 * d));
        checkOutput({tag, "_nkeys"}, 128'(exp_idx), 128'd11);
    endtask

    task automatic handshake();
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        checkOutput("post_hs_valid", 128'(valid_o), 128'd0);
        checkOutput("post_hs_ready", 128'(ready_o), 128'd1);
    endtask

    task automatic runBlock(input string tag, input block_t pt, input int d, input int l, output int lat);
        key_delay = d;
        rtf_lat   = l;
        applyStimulus(pt);
        waitForValid(lat);
        checkBlock(tag, aesRef(pt), lat, d, l);
        handshake();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int     lat0, lat1, lat_tmp, g, starts;
        block_t pa, pb, exp_a, exp_b;

        rst     = 1'b1;
        start_i = 1'b0;
        pt_i    = '0;
        ready_i = 1'b0;
        buildSbox();
        expandKey(FIPS_KEY);
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ref_fips", aesRef(FIPS_PT), FIPS_CT);

        $display("[TB] FIPS-197 C.1, zero-wait keys");
        runBlock("fips0", FIPS_PT, 0, 2, lat0);
        checkOutput("fips0_const", aesRef(FIPS_PT), FIPS_CT);

        $display("[TB] FIPS-197 C.1, 3-cycle key delay");
        key_delay = 3;
        rtf_lat   = 2;
        applyStimulus(FIPS_PT);
        waitForValid(lat1);
        checkOutput("fips3_ct", ct_o, FIPS_CT);
        handshake();
        checkOutput("fips3_lat_delta", 128'(lat1 - lat0), 128'd33);

        $display("[TB] back-pressure");
        expandKey(randBlock());
        pa = randBlock();
        exp_a = aesRef(pa);
        key_delay = 1;
        rtf_lat   = 1;
        applyStimulus(pa);
        waitForValid(lat_tmp);
        for (int i = 0; i < 5; i++) begin
            start_i = (i % 2 == 0);
            pt_i    = randBlock();
            @(negedge clk);
            checkOutput("bp_valid", 128'(valid_o), 128'd1);
            checkOutput("bp_ct", ct_o, exp_a);
            checkOutput("bp_noreq", 128'(rk_req_o), 128'd0);
        end
        ready_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        start_i = 1'b0;
        checkOutput("hs_start_ignored_ready", 128'(ready_o), 128'd1);
        checkOutput("hs_start_ignored_req", 128'(rk_req_o), 128'd0);
        @(negedge clk);
        checkOutput("hs_start_ignored_ready2", 128'(ready_o), 128'd1);

        $display("[TB] reset during WAIT of round 5");
        expandKey(FIPS_KEY);
        key_delay = 0;
        rtf_lat   = 3;
        applyStimulus(FIPS_PT);
        starts = 0;
        for (int i = 0; i < 500 && starts < 5; i++) begin
            if (rtf_start_o) starts++;
            if (starts < 5) @(negedge clk);
        end
        checkOutput("rst_reach_round5", 128'(starts), 128'd5);
        @(negedge clk);
        checkOutput("rst_in_wait_ready", 128'(ready_o), 128'd0);
        rst = 1'b1;
        @(negedge clk);
        checkResetValues("midrst");
        rst = 1'b0;
        @(negedge clk);
        runBlock("after_rst", FIPS_PT, 0, 2, lat_tmp);

        $display("[TB] back-to-back blocks");
        expandKey(randBlock());
        pa = randBlock();
        pb = randBlock();
        exp_a = aesRef(pa);
        exp_b = aesRef(pb);
        key_delay = 0;
        rtf_lat   = 2;
        applyStimulus(pa);
        waitForValid(lat_tmp);
        checkBlock("b2b_a", exp_a, lat_tmp, 0, 2);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        applyStimulus(pb);
        waitForValid(lat_tmp);
        checkBlock("b2b_b", exp_b, lat_tmp, 0, 2);
        handshake();

        $display("[TB] random blocks");
        for (int n = 0; n < 4; n++) begin
            expandKey(randBlock());
            runBlock("rand", randBlock(), int'($urandom_range(0, 2)), int'($urandom_range(1, 4)), lat_tmp);
        end

`ifdef AES_SCHED_TIMEOUT_EN
        $display("[TB] watchdog timeout");
        rtf_stall = 1'b1;
        key_delay = 0;
        rtf_lat   = 2;
        applyStimulus(randBlock());
        g = -1;
        for (int i = 0; i < 100 && g < 0; i++) begin
            if (rtf_start_o) g = cyc;
            else @(negedge clk);
        end
        checkOutput("wdog_go_seen", 128'(g >= 0), 128'd1);
        if (g >= 0) begin
            while (cyc < g + TIMEOUT_CYCLES) @(negedge clk);
            checkOutput("wdog_err_before", 128'(err_o), 128'd0);
            @(negedge clk);
            checkOutput("wdog_err_at", 128'(err_o), 128'd1);
            checkOutput("wdog_err_ready", 128'(ready_o), 128'd0);
            repeat (10) @(negedge clk);
            checkOutput("wdog_err_sticky", 128'(err_o), 128'd1);
            checkOutput("wdog_err_noreq", 128'(rk_req_o), 128'd0);
            checkOutput("wdog_err_nostart", 128'(rtf_start_o), 128'd0);
        end
        rtf_stall = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkResetValues("wdog_rst");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
